cfu_rsp_buffer: RTL and testbench
=================================

# cfu_rsp_buffer

Elastic command/response adapter between the CPU's CFU port and the dual-port-RAM CFU core. The core has a fixed response latency and cannot stall, so this block admits commands only when a response slot is guaranteed and parks every core result in a small FIFO until the CPU takes it. This gives the CPU a fully compliant valid/ready handshake on both channels, with true backpressure.

## Interface
- `DEPTH`, default 4: number of response slots. Power of 2, at least 2.
- `LATENCY`, default 1: core response latency in cycles, range 1..4.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `cmd_valid`  in  1  CPU command valid.
- `cmd_ready`  out  1  command accepted this cycle when high with `cmd_valid`.
- `cmd_payload_function_id`  in  10  passed to core.
- `cmd_payload_inputs_0` / `cmd_payload_inputs_1`  in  32 each  passed to core.
- `rsp_valid`  out  1  FIFO head valid.
- `rsp_ready`  in  1  CPU takes the head.
- `rsp_payload_outputs_0`  out  32  FIFO head data.
- `core_cmd_valid`  out  1  issue strobe to core.
- `core_cmd_payload_function_id`  out  10  to core.
- `core_cmd_payload_inputs_0` / `core_cmd_payload_inputs_1`  out  32 each  to core.
- `core_rsp_valid`  in  1  core's own response flag; checked, not trusted.
- `core_rsp_payload_outputs_0`  in  32  core result.
- `err_sticky`  out  1  protocol mismatch seen since reset.

## Operation
- **Credit count.** `count` (width log2(DEPTH)+1) holds the number of FIFO entries plus in-flight commands.
  - Incremented on accept (`cmd_valid & cmd_ready`).
  - Decremented on pop (`rsp_valid & rsp_ready`).
  - On simultaneous accept and pop, `count` is unchanged.
- **Command side.**
  - `cmd_ready` = (`count` < `DEPTH`), decoded from registered `count` only. There is no combinational path from `rsp_ready` to `cmd_ready`.
  - `core_cmd_valid` = `cmd_valid & cmd_ready`.
  - Core payloads are combinational pass-throughs of the CPU payloads.
- **In-flight tracker.** `track` is a `LATENCY`-bit shift register, with `track[0]` <= accept each cycle.
  - When `track[LATENCY-1]` is 1, `core_rsp_payload_outputs_0` is written to the FIFO tail on that clock edge.
  - The credit rule guarantees the FIFO is never full at a write. If that invariant is ever violated, the write is dropped and `err_sticky` is set.
- **FIFO.** Circular buffer with read/write pointers of log2(DEPTH)+1 bits.
  - Empty when pointers are equal. Full when only the MSBs differ.
  - Pointers wrap naturally at 2*DEPTH.
  - `rsp_valid` = not empty. `rsp_payload_outputs_0` = `mem[rd_ptr]`.
  - Simultaneous write and pop are allowed in any non-full state, including a one-entry FIFO.
- **Error flag.** `err_sticky` is set in any cycle where `core_rsp_valid` != `track[LATENCY-1]`. It is cleared only by reset.
- **Ordering.** Responses return strictly in command order. Data is never reordered, duplicated or dropped.

## Timing
- **Reset values.** While `reset` = 0:
  - `cmd_ready` = 0, `core_cmd_valid` = 0.
  - `rsp_valid` = 0, `err_sticky` = 0.
  - `count`, `track` and pointers = 0.
  - FIFO data contents are don't-care.
- **After reset release.** `cmd_ready` = 1 from the first cycle with `reset` = 1.
- **Latency.** A command accepted in cycle t gives `rsp_valid` = 1 in cycle t+LATENCY+1 when the FIFO was empty.
- **Throughput.** One command per cycle, sustained, when `DEPTH` >= `LATENCY`+2 and `rsp_ready` is held high.
- **Full.** With `count` = `DEPTH`, `cmd_ready` = 0. A pop in cycle t raises `cmd_ready` in cycle t+1.
- **Stalled CPU.** With `rsp_ready` held low, exactly `DEPTH` commands are accepted; then `cmd_ready` stays 0 indefinitely.
- **Reset mid-operation.** Asserting `reset` drops all queued and in-flight responses immediately. No response from pre-reset commands may appear after release.
- **Response-channel rule.** `rsp_payload_outputs_0` is stable while `rsp_valid` = 1 and `rsp_ready` = 0.

## Test plan
- **Single command.** Reset, then issue one command with inputs_0 = 0x10.
  - Core model returns 0xCAFE0001 at LATENCY = 1.
  - Required: `rsp_valid` rises 2 cycles after accept with data 0xCAFE0001; `err_sticky` = 0.
- **Streaming.** 16 back-to-back commands, `rsp_ready` = 1, core returns inputs_0 + 8.
  - Required: `cmd_ready` never drops, and 16 responses arrive in order with values x+8.
- **Backpressure.** `rsp_ready` = 0, 6 commands offered, DEPTH = 4.
  - Required: exactly 4 accepted and `cmd_ready` = 0 thereafter.
  - Then one pop; `cmd_ready` = 1 on the next cycle; the 5th command is accepted.
- **Simultaneous accept and pop at full.** FIFO holds 3 entries plus 1 in flight; hold `rsp_ready` = 1 and offer a command in the same cycle.
  - Required: `count` stays 4, data order is preserved, and the FIFO pointers wrap past index 3 correctly.
- **Protocol mismatch.** Core model pulses `core_rsp_valid` one cycle early.
  - Required: `err_sticky` = 1 and remains 1 until reset.
- **Reset mid-operation.** Assert `reset` with 3 responses queued and 1 in flight, then release.
  - Required: `rsp_valid` = 0 throughout and after release until a new command completes.

Source files
------------

// File: rtl/cfu_rsp_buffer.sv
// Credit-based command/response adapter between the CPU CFU port and a fixed-latency,
// non-stallable CFU core; core results are parked in a small FIFO until the CPU takes them.
module cfu_rsp_buffer #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic        core_cmd_valid,
    output logic [9:0]  core_cmd_payload_function_id,
    output logic [31:0] core_cmd_payload_inputs_0,
    output logic [31:0] core_cmd_payload_inputs_1,
    input  logic        core_rsp_valid,
    input  logic [31:0] core_rsp_payload_outputs_0,
    output logic        err_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int unsigned LAT_U = LATENCY;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [AW:0]        count;
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [LATENCY-1:0] track;
    logic [31:0]        mem [DEPTH];
    logic               accept;
    logic               pop;
    logic               wr_req;
    logic               wr_en;
    logic               empty;
    logic               full;
    logic               err_q;

    // Ready depends only on registered credits; reset gating keeps it low while held in reset.
    assign cmd_ready = reset & (count < DEPTH_L);
    assign accept    = cmd_valid & cmd_ready;

    assign core_cmd_valid               = accept;
    assign core_cmd_payload_function_id = cmd_payload_function_id;
    assign core_cmd_payload_inputs_0    = cmd_payload_inputs_0;
    assign core_cmd_payload_inputs_1    = cmd_payload_inputs_1;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign rsp_valid             = ~empty;
    assign pop                   = rsp_valid & rsp_ready;
    assign rsp_payload_outputs_0 = mem[rd_ptr[AW-1:0]];

    assign wr_req     = track[LATENCY-1];
    assign wr_en      = wr_req & ~full;
    assign err_sticky = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            track  <= '0;
            err_q  <= 1'b0;
        end else begin
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            track[0] <= accept;
            for (int unsigned i = 1; i < LAT_U; i++) begin
                track[i] <= track[i-1];
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A write into a full FIFO means the credit invariant broke; drop it and flag.
            if ((core_rsp_valid != wr_req) || (wr_req && full)) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= core_rsp_payload_outputs_0;
        end
    end

endmodule

// File: tb/tb_cfu_rsp_buffer.sv
// Directed bench for cfu_rsp_buffer: queue-based reference model checked every cycle,
// plus literal expectations for latency, backpressure, ordering, error flag and reset.
module tb_cfu_rsp_buffer;

    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  fid;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        core_cmd_valid;
    logic [9:0]  core_fid;
    logic [31:0] core_in0;
    logic [31:0] core_in1;
    logic        core_rsp_valid;
    logic [31:0] core_rsp_data;
    logic        err_sticky;

    logic [31:0] core_add;
    logic        early_mode;

    cfu_rsp_buffer #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .cmd_valid                    (cmd_valid),
        .cmd_ready                    (cmd_ready),
        .cmd_payload_function_id      (fid),
        .cmd_payload_inputs_0         (in0),
        .cmd_payload_inputs_1         (in1),
        .rsp_valid                    (rsp_valid),
        .rsp_ready                    (rsp_ready),
        .rsp_payload_outputs_0        (rsp_data),
        .core_cmd_valid               (core_cmd_valid),
        .core_cmd_payload_function_id (core_fid),
        .core_cmd_payload_inputs_0    (core_in0),
        .core_cmd_payload_inputs_1    (core_in1),
        .core_rsp_valid               (core_rsp_valid),
        .core_rsp_payload_outputs_0   (core_rsp_data),
        .err_sticky                   (err_sticky)
    );

    always #5 clk = ~clk;

    // Core model: fixed latency, result = inputs_0 + core_add; early_mode fakes an early valid.
    logic [LAT-1:0] cp_v;
    logic [31:0]    cp_d [LAT];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cp_v <= '0;
        end else begin
            cp_v[0] <= core_cmd_valid;
            cp_d[0] <= core_in0 + core_add;
            for (int i = 1; i < LAT; i++) begin
                cp_v[i] <= cp_v[i-1];
                cp_d[i] <= cp_d[i-1];
            end
        end
    end
    assign core_rsp_valid = early_mode ? core_cmd_valid : cp_v[LAT-1];
    assign core_rsp_data  = cp_d[LAT-1];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: visible FIFO contents plus pending results with their due edge.
    logic [31:0] m_fifo[$];
    logic [31:0] m_pend_data[$];
    int unsigned m_pend_due[$];
    logic        m_err;
    always @(posedge clk or negedge reset) begin
        logic acc, due, corev;
        if (!reset) begin
            m_fifo.delete();
            m_pend_data.delete();
            m_pend_due.delete();
            m_err = 1'b0;
        end else begin
            acc   = cmd_valid && ((m_fifo.size() + m_pend_data.size()) < DEPTH);
            due   = (m_pend_due.size() > 0) && (m_pend_due[0] == cyc);
            corev = early_mode ? acc : due;
            if (corev != due) m_err = 1'b1;
            if (m_fifo.size() > 0 && rsp_ready) void'(m_fifo.pop_front());
            if (due) begin
                m_fifo.push_back(m_pend_data.pop_front());
                void'(m_pend_due.pop_front());
            end
            if (acc) begin
                m_pend_data.push_back(in0 + core_add);
                m_pend_due.push_back(cyc + LAT);
            end
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic exp_ready;
        exp_ready = reset && ((m_fifo.size() + m_pend_data.size()) < DEPTH);
        chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, exp_ready});
        chk("core_cmd_valid", {31'b0, core_cmd_valid}, {31'b0, cmd_valid && exp_ready});
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, reset && (m_fifo.size() > 0)});
        if (reset && m_fifo.size() > 0) chk("rsp_data", rsp_data, m_fifo[0]);
        chk("err_sticky", {31'b0, err_sticky}, {31'b0, reset && m_err});
        chk("core_fid", {22'b0, core_fid}, {22'b0, fid});
        chk("core_in0", core_in0, in0);
        chk("core_in1", core_in1, in1);
    end

    logic [31:0] rx[$];
    always @(negedge clk) if (rsp_valid && rsp_ready) rx.push_back(rsp_data);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc_cyc;
        int          drops;
        int          nacc;
        int          n;
        logic        got;

        reset = 1'b0; cmd_valid = 1'b0; fid = 10'h3A; in0 = '0; in1 = 32'h55;
        rsp_ready = 1'b0; core_add = '0; early_mode = 1'b0;
        repeat (3) step();

        // Held in reset with a command offered.
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("reset_core_cmd_valid", {31'b0, core_cmd_valid}, 32'd0);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_err", {31'b0, err_sticky}, 32'd0);
        step();
        cmd_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {31'b0, cmd_ready}, 32'd1);

        // Single command.
        step();
        core_add = 32'hCAFDFFF1;
        cmd_valid = 1'b1; in0 = 32'h10;
        @(negedge clk);
        acc_cyc = cyc;
        step();
        cmd_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        chk("single_seen", {31'b0, got}, 32'd1);
        chk("single_latency", cyc - acc_cyc, 32'd2);
        chk("single_data", rsp_data, 32'hCAFE0001);
        chk("single_err", {31'b0, err_sticky}, 32'd0);
        step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Streaming, 16 back-to-back.
        rx.delete();
        core_add = 32'd8;
        rsp_ready = 1'b1;
        drops = 0;
        for (int i = 0; i < 16; i++) begin
            cmd_valid = 1'b1; in0 = 32'h100 + 32'(i * 3);
            @(negedge clk);
            if (!cmd_ready) drops++;
            step();
        end
        cmd_valid = 1'b0;
        repeat (6) step();
        chk("stream_drops", 32'(drops), 32'd0);
        chk("stream_count", 32'(rx.size()), 32'd16);
        for (int i = 0; i < rx.size(); i++) chk("stream_data", rx[i], 32'h108 + 32'(i * 3));

        // Backpressure: 6 offered with rsp_ready low.
        rx.delete();
        rsp_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 10; i++) begin
            cmd_valid = (nacc < 6); in0 = 32'h200 + 32'(nacc * 16);
            @(negedge clk);
            if (cmd_valid && cmd_ready) nacc++;
            step();
        end
        chk("bp_accepted", 32'(nacc), 32'd4);
        @(negedge clk);
        chk("bp_ready_low", {31'b0, cmd_ready}, 32'd0);
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_during_pop", {31'b0, cmd_ready}, 32'd0);
        step();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready_after_pop", {31'b0, cmd_ready}, 32'd1);
        if (cmd_ready) nacc++;
        step();
        cmd_valid = 1'b0;
        chk("bp_fifth_accepted", 32'(nacc), 32'd5);
        rsp_ready = 1'b1;
        repeat (8) step();
        rsp_ready = 1'b0;
        chk("bp_count", 32'(rx.size()), 32'd5);
        for (int i = 0; i < rx.size(); i++) chk("bp_data", rx[i], 32'h208 + 32'(i * 16));

        // Fill to 3 queued + 1 in flight, then accept and pop together.
        rx.delete();
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; in0 = 32'h300 + 32'(i);
            step();
        end
        n = 4;
        for (int i = 0; i < 14; i++) begin
            rsp_ready = 1'b1;
            cmd_valid = (n < 12); in0 = 32'h300 + 32'(n);
            @(negedge clk);
            if (i == 0) chk("full_ready_low", {31'b0, cmd_ready}, 32'd0);
            if (cmd_valid && cmd_ready) n++;
            step();
        end
        cmd_valid = 1'b0;
        repeat (8) step();
        rsp_ready = 1'b0;
        chk("wrap_sent", 32'(n), 32'd12);
        chk("wrap_count", 32'(rx.size()), 32'd12);
        for (int i = 0; i < rx.size(); i++) chk("wrap_data", rx[i], 32'h308 + 32'(i));

        // Core raises its valid one cycle early.
        rsp_ready = 1'b1;
        early_mode = 1'b1;
        cmd_valid = 1'b1; in0 = 32'h400;
        step();
        cmd_valid = 1'b0;
        repeat (3) step();
        early_mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("err_held", {31'b0, err_sticky}, 32'd1);
            step();
        end
        rsp_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("err_cleared_by_reset", {31'b0, err_sticky}, 32'd0);
        step();
        reset = 1'b1;
        step();

        // Reset with 3 queued + 1 in flight.
        rx.delete();
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; in0 = 32'h500 + 32'(i);
            step();
        end
        cmd_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid_low", {31'b0, rsp_valid}, 32'd0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_stale", {31'b0, rsp_valid}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; in0 = 32'h600;
        step();
        cmd_valid = 1'b0;
        repeat (4) step();
        chk("rst_new_count", 32'(rx.size()), 32'd1);
        if (rx.size() > 0) chk("rst_new_data", rx[0], 32'h608);
        chk("rst_err", {31'b0, err_sticky}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
